// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter
// Packet-atomic arbiter that shares one header-insertion datapath between
// NUM_SRC requesters. A source requests when both its header and its first
// payload beat are pending; the winner owns the master stream/header pair
// until its last beat is accepted, then one IDLE cycle follows.
//
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority (lowest index wins); the round-robin pointer then does not exist.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4,
  parameter int ID_WD        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              s_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep,
  input  logic [NUM_SRC-1:0]              s_last,
  output logic [NUM_SRC-1:0]              s_ready,
  input  logic [NUM_SRC-1:0]              s_hdr_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_hdr_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_hdr_keep,
  output logic [NUM_SRC-1:0]              s_hdr_ready,
  output logic                            m_valid,
  output logic [DATA_WD-1:0]              m_data,
  output logic [DATA_BYTE_WD-1:0]         m_keep,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic                            m_hdr_valid,
  output logic [DATA_WD-1:0]              m_hdr_data,
  output logic [DATA_BYTE_WD-1:0]         m_hdr_keep,
  input  logic                            m_hdr_ready,
  output logic                            grant_valid,
  output logic [ID_WD-1:0]                grant_id,
  output logic                            pkt_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ID_WD-1:0] grant_id_q, grant_id_d;
  logic             hdr_done_q, hdr_done_d;
  logic             pkt_done_q, pkt_done_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [ID_WD-1:0] rr_q, rr_d;
`endif

  logic [NUM_SRC-1:0] req;
  assign req = s_valid & s_hdr_valid;

  // Selected source's channels, picked by the registered grant index.
  logic                    sel_valid, sel_last, sel_hdr_valid;
  logic [DATA_WD-1:0]      sel_data, sel_hdr_data;
  logic [DATA_BYTE_WD-1:0] sel_keep, sel_hdr_keep;

  // Mux the granted source onto the sel_* bus.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_hdr_valid = 1'b0;
    sel_data      = '0;
    sel_hdr_data  = '0;
    sel_keep      = '0;
    sel_hdr_keep  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id_q == ID_WD'(i)) begin
        sel_valid     = s_valid[i];
        sel_last      = s_last[i];
        sel_hdr_valid = s_hdr_valid[i];
        sel_data      = s_data[i*DATA_WD +: DATA_WD];
        sel_keep      = s_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_hdr_data  = s_hdr_data[i*DATA_WD +: DATA_WD];
        sel_hdr_keep  = s_hdr_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
      end
    end
  end

  logic             pick_found;
  logic [ID_WD-1:0] pick_id;

  // Choose the next winner among current requesters.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && req[i]) begin
        pick_found = 1'b1;
        pick_id    = ID_WD'(i);
      end
    end
`else
    // First pass: indices at or after the pointer; second pass wraps around.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && req[i] && (ID_WD'(i) >= rr_q)) begin
        pick_found = 1'b1;
        pick_id    = ID_WD'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && req[i] && (ID_WD'(i) < rr_q)) begin
        pick_found = 1'b1;
        pick_id    = ID_WD'(i);
      end
    end
`endif
  end

  logic hdr_hs, last_hs;

  // FSM next state, handshake steering and master-side outputs.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    hdr_done_d  = hdr_done_q;
    pkt_done_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    s_ready     = '0;
    s_hdr_ready = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_keep      = '0;
    m_last      = 1'b0;
    m_hdr_valid = 1'b0;
    m_hdr_data  = '0;
    m_hdr_keep  = '0;
    grant_valid = 1'b0;
    hdr_hs      = 1'b0;
    last_hs     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hdr_done_d = 1'b0;
        if (pick_found) begin
          grant_id_d = pick_id;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        grant_valid = 1'b1;
        // Header goes out once, alongside the first beat.
        m_hdr_valid = sel_hdr_valid & ~hdr_done_q;
        if (m_hdr_valid) begin
          m_hdr_data = sel_hdr_data;
          m_hdr_keep = sel_hdr_keep;
        end
        // First beat waits for its header so the inserter sees both together.
        m_valid = sel_valid & (hdr_done_q | sel_hdr_valid);
        if (m_valid) begin
          m_data = sel_data;
          m_keep = sel_keep;
          m_last = sel_last;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_id_q == ID_WD'(i)) begin
            s_ready[i]     = m_ready & (hdr_done_q | m_hdr_ready);
            s_hdr_ready[i] = m_hdr_ready & ~hdr_done_q;
          end
        end

        hdr_hs  = m_hdr_valid & m_hdr_ready;
        last_hs = m_valid & m_ready & m_last;

        if (last_hs) begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
          hdr_done_d = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          rr_d = (grant_id_q == ID_WD'(NUM_SRC - 1)) ? '0 : grant_id_q + ID_WD'(1);
`endif
        end else if (hdr_hs) begin
          hdr_done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_id = grant_id_q;
  assign pkt_done = pkt_done_q;

  // State registers with synchronous reset; reset abandons any packet.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      hdr_done_q <= 1'b0;
      pkt_done_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      hdr_done_q <= hdr_done_d;
      pkt_done_q <= pkt_done_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed bench for axi_stream_header_arbiter: reset, basic packet,
// arbitration order, single-beat packet, backpressure, header-before-data,
// and reset mid-packet.
module tb_axi_stream_header_arbiter;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NS = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS-1:0]    s_valid, s_last, s_ready, s_hdr_valid, s_hdr_ready;
  logic [NS*DW-1:0] s_data, s_hdr_data;
  logic [NS*BW-1:0] s_keep, s_hdr_keep;
  logic             m_valid, m_last, m_ready, m_hdr_valid, m_hdr_ready;
  logic [DW-1:0]    m_data, m_hdr_data;
  logic [BW-1:0]    m_keep, m_hdr_keep;
  logic             grant_valid, pkt_done;
  logic [IW-1:0]    grant_id;

  int passed = 0;
  int total  = 0;

  axi_stream_header_arbiter #(
    .DATA_WD(DW), .DATA_BYTE_WD(BW), .NUM_SRC(NS), .ID_WD(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .s_ready(s_ready),
    .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep),
    .s_hdr_ready(s_hdr_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_ready(m_ready),
    .m_hdr_valid(m_hdr_valid), .m_hdr_data(m_hdr_data), .m_hdr_keep(m_hdr_keep),
    .m_hdr_ready(m_hdr_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .pkt_done(pkt_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s_valid = '0; s_data = '0; s_keep = '0; s_last = '0;
    s_hdr_valid = '0; s_hdr_data = '0; s_hdr_keep = '0;
  endtask

  task automatic drive_beat(input int i, input logic v, input logic [DW-1:0] d,
                            input logic [BW-1:0] k, input logic l);
    for (int j = 0; j < NS; j++) begin
      if (j == i) begin
        s_valid[j] = v; s_data[j*DW +: DW] = d; s_keep[j*BW +: BW] = k; s_last[j] = l;
      end
    end
  endtask

  task automatic drive_hdr(input int i, input logic v, input logic [DW-1:0] d,
                           input logic [BW-1:0] k);
    for (int j = 0; j < NS; j++) begin
      if (j == i) begin
        s_hdr_valid[j] = v; s_hdr_data[j*DW +: DW] = d; s_hdr_keep[j*BW +: BW] = k;
      end
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    m_ready = 1'b1; m_hdr_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({s_ready, s_hdr_ready, m_valid, m_hdr_valid, m_last, grant_valid, pkt_done} !== '0)
      $display("FAIL reset_ctrl got %b want 0",
               {s_ready, s_hdr_ready, m_valid, m_hdr_valid, m_last, grant_valid, pkt_done});
    else passed++;
    total++;
    if ({m_data, m_keep, m_hdr_data, m_hdr_keep, grant_id} !== '0)
      $display("FAIL reset_data got %h want 0", {m_data, m_keep, m_hdr_data, m_hdr_keep, grant_id});
    else passed++;
  endtask

  task automatic test_src1_packet();
    do_reset();
    drive_hdr(1, 1'b1, 32'hA1A1_0001, 4'b0011);
    drive_beat(1, 1'b1, 32'h1000_0010, 4'hF, 1'b0);
    settle();
    total++;
    if ({grant_valid, s_ready, s_hdr_ready} !== 9'b0)
      $display("FAIL src1_idle got %b want 0", {grant_valid, s_ready, s_hdr_ready});
    else passed++;
    step();
    total++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd1})
      $display("FAIL src1_grant got %b/%0d want 1/1", grant_valid, grant_id);
    else passed++;
    total++;
    if ({m_hdr_valid, m_hdr_data, m_hdr_keep} !== {1'b1, 32'hA1A1_0001, 4'b0011})
      $display("FAIL src1_hdr got %b %h %b want 1 a1a10001 0011", m_hdr_valid, m_hdr_data, m_hdr_keep);
    else passed++;
    total++;
    if ({m_valid, m_data, m_last, s_ready, s_hdr_ready} !== {1'b1, 32'h1000_0010, 1'b0, 4'b0010, 4'b0010})
      $display("FAIL src1_beat0 got %b %h %b %b %b", m_valid, m_data, m_last, s_ready, s_hdr_ready);
    else passed++;
    step();
    drive_hdr(1, 1'b0, '0, '0);
    drive_beat(1, 1'b1, 32'h1000_0011, 4'hF, 1'b0);
    settle();
    total++;
    if ({m_hdr_valid, s_hdr_ready, m_valid, m_data, m_last, s_ready} !==
        {1'b0, 4'b0000, 1'b1, 32'h1000_0011, 1'b0, 4'b0010})
      $display("FAIL src1_beat1 got %b %b %b %h %b %b", m_hdr_valid, s_hdr_ready, m_valid, m_data, m_last, s_ready);
    else passed++;
    step();
    drive_beat(1, 1'b1, 32'h1000_0012, 4'b0111, 1'b1);
    settle();
    total++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h1000_0012, 4'b0111, 1'b1})
      $display("FAIL src1_beat2 got %b %h %b %b want 1 10000012 0111 1", m_valid, m_data, m_keep, m_last);
    else passed++;
    step();
    drive_beat(1, 1'b0, '0, '0, 1'b0);
    settle();
    total++;
    if ({pkt_done, grant_valid, m_valid} !== 3'b100)
      $display("FAIL src1_done got %b want 100", {pkt_done, grant_valid, m_valid});
    else passed++;
    step();
    total++;
    if (pkt_done !== 1'b0)
      $display("FAIL src1_done_pulse got %b want 0", pkt_done);
    else passed++;
  endtask

  task automatic test_alternate();
    logic       hdr_pend [NS];
    int         beat [NS];
    logic [11:0] gv;
    logic [IW-1:0] gid [12];
    logic [NS-1:0] hs, hh;
    logic [IW-1:0] exp_id [4];
`ifdef ARB_FIXED_PRIO_EN
    exp_id = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_id = '{2'd0, 2'd2, 2'd0, 2'd2};
`endif
    do_reset();
    for (int j = 0; j < NS; j++) begin hdr_pend[j] = 1'b1; beat[j] = 0; end
    gv = '0;
    for (int c = 0; c < 12; c++) begin
      for (int j = 0; j < NS; j++) begin
        if (j == 0 || j == 2) begin
          drive_hdr(j, hdr_pend[j], 32'hB000_0000 | DW'(j), 4'hF);
          drive_beat(j, 1'b1, 32'hC000_0000 | DW'(j << 8) | DW'(beat[j]), 4'hF, beat[j] == 1);
        end
      end
      settle();
      gv[c]  = grant_valid;
      gid[c] = grant_id;
      hs = s_valid & s_ready;
      hh = s_hdr_valid & s_hdr_ready;
      step();
      for (int j = 0; j < NS; j++) begin
        if (hh[j]) hdr_pend[j] = 1'b0;
        if (hs[j]) begin
          if (beat[j] == 1) begin beat[j] = 0; hdr_pend[j] = 1'b1; end
          else beat[j] = 1;
        end
      end
    end
    clear_inputs();
    total++;
    if (gv !== 12'b110110110110)
      $display("FAIL alt_busy_pattern got %b want 110110110110", gv);
    else passed++;
    for (int p = 0; p < 4; p++) begin
      total++;
      if (gid[1 + 3*p] !== exp_id[p])
        $display("FAIL alt_grant%0d got %0d want %0d", p, gid[1 + 3*p], exp_id[p]);
      else passed++;
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    drive_hdr(3, 1'b1, 32'hD3D3_0003, 4'hF);
    drive_beat(3, 1'b1, 32'hE000_0003, 4'b0001, 1'b1);
    step();
    total++;
    if ({grant_valid, grant_id, m_valid, m_last, m_hdr_valid, s_ready, s_hdr_ready} !==
        {1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000})
      $display("FAIL single_busy got %b %0d %b %b %b %b %b", grant_valid, grant_id, m_valid,
               m_last, m_hdr_valid, s_ready, s_hdr_ready);
    else passed++;
    total++;
    if ({m_data, m_keep} !== {32'hE000_0003, 4'b0001})
      $display("FAIL single_data got %h %b want e0000003 0001", m_data, m_keep);
    else passed++;
    step();
    clear_inputs();
    settle();
    total++;
    if ({grant_valid, pkt_done} !== 2'b01)
      $display("FAIL single_one_cycle got %b want 01", {grant_valid, pkt_done});
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [8];
    int   n = 0;
    int   b0 = 0;
    logic hp0 = 1'b1;
    logic leak = 1'b0;
    logic finished = 1'b0;
    logic hs0, hh0, lst;
    do_reset();
    drive_hdr(1, 1'b1, 32'hB1B1_0001, 4'hF);
    drive_beat(1, 1'b1, 32'hDEAD_0001, 4'hF, 1'b1);
    for (int c = 0; c < 40 && !finished; c++) begin
      m_ready = c[0];
      drive_hdr(0, hp0, 32'hB0B0_0000, 4'hF);
      drive_beat(0, b0 < 4, 32'hF000_0000 | DW'(b0), 4'hF, b0 == 3);
      settle();
      if (s_ready[1] | s_hdr_ready[1]) leak = 1'b1;
      if (m_valid && m_ready && n < 8) begin got[n] = m_data; n++; end
      hs0 = s_valid[0] & s_ready[0];
      hh0 = s_hdr_valid[0] & s_hdr_ready[0];
      lst = s_last[0];
      step();
      if (hh0) hp0 = 1'b0;
      if (hs0) begin
        b0++;
        if (lst) finished = 1'b1;
      end
    end
    clear_inputs();
    m_ready = 1'b1;
    total++;
    if (finished !== 1'b1) $display("FAIL bp_timeout got %b want 1", finished);
    else passed++;
    total++;
    if (leak !== 1'b0) $display("FAIL bp_src1_ready got %b want 0", leak);
    else passed++;
    total++;
    if (n !== 4) $display("FAIL bp_beat_count got %0d want 4", n);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k < n && got[k] !== (32'hF000_0000 | DW'(k)))
        $display("FAIL bp_order%0d got %h want %h", k, got[k], 32'hF000_0000 | DW'(k));
      else if (k >= n) $display("FAIL bp_order%0d got none want %h", k, 32'hF000_0000 | DW'(k));
      else passed++;
    end
  endtask

  task automatic test_hdr_early();
    do_reset();
    drive_hdr(2, 1'b1, 32'hC2C2_0002, 4'hF);
    for (int c = 0; c < 2; c++) begin
      settle();
      total++;
      if ({grant_valid, s_hdr_ready, m_hdr_valid} !== 6'b0)
        $display("FAIL early_wait%0d got %b want 0", c, {grant_valid, s_hdr_ready, m_hdr_valid});
      else passed++;
      step();
    end
    drive_beat(2, 1'b1, 32'h2222_0000, 4'hF, 1'b0);
    settle();
    total++;
    if (grant_valid !== 1'b0) $display("FAIL early_latency got %b want 0", grant_valid);
    else passed++;
    step();
    total++;
    if ({grant_valid, grant_id, s_hdr_ready, m_hdr_valid, m_valid} !== {1'b1, 2'd2, 4'b0100, 1'b1, 1'b1})
      $display("FAIL early_grant got %b %0d %b %b %b", grant_valid, grant_id, s_hdr_ready, m_hdr_valid, m_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    // Complete a single-beat src1 packet so the pointer moves off zero.
    drive_hdr(1, 1'b1, 32'hA1A1_0009, 4'hF);
    drive_beat(1, 1'b1, 32'h9000_0000, 4'hF, 1'b1);
    step(); step();
    // Start a 4-beat src1 packet.
    drive_beat(1, 1'b1, 32'h9000_0010, 4'hF, 1'b0);
    step(); step();
    drive_hdr(1, 1'b0, '0, '0);
    drive_beat(1, 1'b1, 32'h9000_0011, 4'hF, 1'b0);
    settle();
    total++;
    if ({grant_valid, grant_id, m_valid, m_data} !== {1'b1, 2'd1, 1'b1, 32'h9000_0011})
      $display("FAIL rstmid_beat1 got %b %0d %b %h", grant_valid, grant_id, m_valid, m_data);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if ({s_ready, s_hdr_ready, m_valid, m_hdr_valid, m_last, grant_valid, pkt_done, grant_id} !== '0)
      $display("FAIL rstmid_ctrl got %b want 0",
               {s_ready, s_hdr_ready, m_valid, m_hdr_valid, m_last, grant_valid, pkt_done, grant_id});
    else passed++;
    total++;
    if ({m_data, m_keep, m_hdr_data, m_hdr_keep} !== '0)
      $display("FAIL rstmid_data got %h want 0", {m_data, m_keep, m_hdr_data, m_hdr_keep});
    else passed++;
    rst = 1'b0;
    clear_inputs();
    drive_hdr(0, 1'b1, 32'hA0A0_0000, 4'hF);
    drive_beat(0, 1'b1, 32'h0000_00AA, 4'hF, 1'b1);
    drive_hdr(3, 1'b1, 32'hA3A3_0000, 4'hF);
    drive_beat(3, 1'b1, 32'h0000_00BB, 4'hF, 1'b1);
    step();
    total++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd0})
      $display("FAIL rstmid_rr_ptr got %b/%0d want 1/0", grant_valid, grant_id);
    else passed++;
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    m_ready = 1'b1;
    m_hdr_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_src1_packet();
    test_alternate();
    test_single_beat();
    test_backpressure();
    test_hdr_early();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
